// File: rtl/surf_event_merger.sv
// surf_event_merger: merges one frame per enabled SURF, in index order, into a single AXI4-Stream per event.
// Define SURF_MERGE_HEADER_EN to prefix every started frame with a one-byte header {4'hA, 1'b0, index}.
module surf_event_merger #(
    parameter int NSURF          = 7,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 sysclk_i,
    input  logic                 aresetn_i,
    input  logic [NSURF-1:0]     surf_mask_i,
    input  logic [8*NSURF-1:0]   s_tdata,
    input  logic [NSURF-1:0]     s_tvalid,
    input  logic [NSURF-1:0]     s_tlast,
    output logic [NSURF-1:0]     s_tready,
    output logic [7:0]           m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic [2:0]           m_tuser,
    output logic                 event_done_o,
    output logic [NSURF-1:0]     missing_o,
    output logic [CNT_WIDTH-1:0] event_count_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
`ifdef SURF_MERGE_HEADER_EN
        ST_HDR,
`endif
        ST_DATA,
        ST_NEXT
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           cur_q, cur_d;
    logic [NSURF-1:0]     mask_q, mask_d;
    logic [NSURF-1:0]     miss_acc_q, miss_acc_d;
    logic [NSURF-1:0]     missing_q, missing_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 done_q, done_d;

    logic [7:0]           cur_data;
    logic                 cur_valid;
    logic                 cur_last;
    logic [NSURF-1:0]     above_mask;

    function automatic logic [2:0] lowest_idx(input logic [NSURF-1:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int k = NSURF - 1; k >= 0; k--) begin
            if (m[k]) idx = 3'(k);
        end
        return idx;
    endfunction

    assign cur_data  = s_tdata[{cur_q, 3'b000} +: 8];
    assign cur_valid = s_tvalid[cur_q];
    assign cur_last  = s_tlast[cur_q];

    // Enabled SURFs still to be visited after the current one.
    always_comb begin
        above_mask = '0;
        for (int k = 0; k < NSURF; k++) begin
            above_mask[k] = mask_q[k] && (k > int'(cur_q));
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        state_d    = state_q;
        cur_d      = cur_q;
        mask_d     = mask_q;
        miss_acc_d = miss_acc_q;
        missing_d  = missing_q;
        timer_d    = timer_q;
        count_d    = count_q;
        done_d     = 1'b0;
        m_tdata    = '0;
        m_tvalid   = 1'b0;
        m_tlast    = 1'b0;
        m_tuser    = '0;
        s_tready   = '0;

        case (state_q)
            ST_IDLE: begin
                if ((s_tvalid & mask_q) != '0) begin
                    cur_d      = lowest_idx(mask_q);
                    miss_acc_d = '0;
                    timer_d    = '0;
                    state_d    = ST_WAIT;
                end else begin
                    mask_d = surf_mask_i;
                end
            end
            ST_WAIT: begin
                // A first byte arriving on the timeout cycle still wins.
                if (cur_valid) begin
                    timer_d = '0;
`ifdef SURF_MERGE_HEADER_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_DATA;
`endif
                end else if (timer_q == TIMER_LAST) begin
                    timer_d           = '0;
                    miss_acc_d[cur_q] = 1'b1;
                    state_d           = ST_NEXT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`ifdef SURF_MERGE_HEADER_EN
            ST_HDR: begin
                m_tdata  = {4'hA, 1'b0, cur_q};
                m_tvalid = 1'b1;
                m_tuser  = cur_q;
                if (m_tready) state_d = ST_DATA;
            end
`endif
            ST_DATA: begin
                m_tdata         = cur_data;
                m_tvalid        = cur_valid;
                m_tlast         = cur_last;
                m_tuser         = cur_q;
                s_tready[cur_q] = m_tready;
                if (cur_valid && m_tready && cur_last) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (above_mask != '0) begin
                    cur_d   = lowest_idx(above_mask);
                    state_d = ST_WAIT;
                end else begin
                    done_d    = 1'b1;
                    missing_d = miss_acc_q;
                    count_d   = count_q + 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sysclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            mask_q     <= '0;
            miss_acc_q <= '0;
            missing_q  <= '0;
            timer_q    <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            mask_q     <= mask_d;
            miss_acc_q <= miss_acc_d;
            missing_q  <= missing_d;
            timer_q    <= timer_d;
            count_q    <= count_d;
            done_q     <= done_d;
        end
    end

    assign event_done_o  = done_q;
    assign missing_o     = missing_q;
    assign event_count_o = count_q;

endmodule

// File: tb/tb_surf_event_merger.sv
// Directed self-checking bench for surf_event_merger (short timeout, 4-bit event counter).
// Expected stream honours SURF_MERGE_HEADER_EN when the bench is built with the same define.
module tb_surf_event_merger;

    localparam int NS = 7;
    localparam int TO = 16;
    localparam int CW = 4;

    logic            sysclk_i = 1'b0;
    logic            aresetn_i;
    logic [NS-1:0]   surf_mask_i;
    logic [8*NS-1:0] s_tdata;
    logic [NS-1:0]   s_tvalid;
    logic [NS-1:0]   s_tlast;
    logic [NS-1:0]   s_tready;
    logic [7:0]      m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic [2:0]      m_tuser;
    logic            event_done_o;
    logic [NS-1:0]   missing_o;
    logic [CW-1:0]   event_count_o;

    surf_event_merger #(
        .NSURF(NS),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH(CW)
    ) dut (
        .sysclk_i     (sysclk_i),
        .aresetn_i    (aresetn_i),
        .surf_mask_i  (surf_mask_i),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tlast      (s_tlast),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .m_tuser      (m_tuser),
        .event_done_o (event_done_o),
        .missing_o    (missing_o),
        .event_count_o(event_count_o)
    );

    always #5 sysclk_i = ~sysclk_i;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [2:0] user;
    } beat_t;

    beat_t         exp_q[$];
    logic [7:0]    src_mem[NS][1024];
    int            src_len[NS];
    int            src_ptr[NS];
    bit            pend[NS];
    bit            src_en;
    bit            gap_en;
    bit            rand_rdy;
    int            fg_idx;
    int            fg_at;
    int            fg_left;
    int            errors;
    int            checks;
    int            tick_no;
    int            done_seen;
    int            done_tick;
    int            last_tick;
    logic [NS-1:0] cap_missing;
    logic [CW-1:0] exp_count;
    bit            prev_stall;
    beat_t         prev_beat;
    bit            bad_ready;
    logic [NS-1:0] cur_mask;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Upstream sources: AXI-compliant, valid held until accepted, optional gaps after the first byte.
    task automatic drive();
        m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int i = 0; i < NS; i++) begin
            logic v;
            v = 1'b0;
            if (src_en && src_ptr[i] < src_len[i]) begin
                if (pend[i]) v = 1'b1;
                else if (i == fg_idx && src_ptr[i] == fg_at && fg_left > 0) fg_left--;
                else v = !(gap_en && src_ptr[i] > 0 && $urandom_range(0, 3) == 0);
            end
            s_tvalid[i] = v;
            pend[i]     = v;
            s_tlast[i]  = v && (src_ptr[i] == src_len[i] - 1);
            if (v) s_tdata[8*i +: 8] = src_mem[i][src_ptr[i]];
            else   s_tdata[8*i +: 8] = 8'h00;
        end
    endtask

    // One clock: sample mid-cycle, clock edge, update models, drive new inputs.
    task automatic tick();
        beat_t         b;
        bit            hs_m;
        logic [NS-1:0] hs_s;
        hs_m = m_tvalid && m_tready;
        hs_s = s_tvalid & s_tready;
        b    = {m_tdata, m_tlast, m_tuser};
        if (prev_stall) check("axi_hold", 32'({m_tvalid, b}), 32'({1'b1, prev_beat}));
        if ((s_tready & ~cur_mask) != '0 || !$onehot0(s_tready)) bad_ready = 1'b1;
        if (hs_m) begin
            if (exp_q.size() == 0) check("extra_beat", 32'(m_tvalid), 32'd0);
            else                   check("beat", 32'(b), 32'(exp_q.pop_front()));
        end
        prev_stall = m_tvalid && !m_tready;
        prev_beat  = b;
        @(posedge sysclk_i);
        tick_no++;
        if (hs_m && b.last) last_tick = tick_no;
        for (int i = 0; i < NS; i++) begin
            if (hs_s[i]) begin
                src_ptr[i]++;
                pend[i] = 1'b0;
            end
        end
        #1;
        if (event_done_o === 1'b1) begin
            done_seen++;
            done_tick   = tick_no;
            cap_missing = missing_o;
        end
        drive();
        #1;
    endtask

    task automatic build_expected(input logic [NS-1:0] mask, output logic [NS-1:0] miss);
        beat_t e;
        miss = '0;
        for (int i = 0; i < NS; i++) begin
            if (mask[i]) begin
                if (src_len[i] == 0) miss[i] = 1'b1;
                else begin
`ifdef SURF_MERGE_HEADER_EN
                    e.data = {4'hA, 1'b0, 3'(i)};
                    e.last = 1'b0;
                    e.user = 3'(i);
                    exp_q.push_back(e);
`endif
                    for (int k = 0; k < src_len[i]; k++) begin
                        e.data = src_mem[i][k];
                        e.last = (k == src_len[i] - 1);
                        e.user = 3'(i);
                        exp_q.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic prepare(input logic [NS-1:0] mask, output logic [NS-1:0] miss);
        surf_mask_i = mask;
        cur_mask    = mask;
        src_en      = 1'b0;
        tick();
        tick();
        for (int i = 0; i < NS; i++) begin
            src_ptr[i] = 0;
            pend[i]    = 1'b0;
        end
        exp_q.delete();
        build_expected(mask, miss);
        bad_ready = 1'b0;
        src_en    = 1'b1;
    endtask

    task automatic run_event(input logic [NS-1:0] mask, input int budget, input string tag);
        logic [NS-1:0] exp_miss;
        int d0;
        int n;
        prepare(mask, exp_miss);
        d0 = done_seen;
        n  = 0;
        while (done_seen == d0 && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
        exp_count++;
        check({tag, "_done_pulses"}, 32'(done_seen - d0), 32'd1);
        check({tag, "_missing"}, 32'(cap_missing), 32'(exp_miss));
        check({tag, "_missing_held"}, 32'(missing_o), 32'(exp_miss));
        check({tag, "_count"}, 32'(event_count_o), 32'(exp_count));
        check({tag, "_leftover_beats"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_ready_leak"}, 32'(bad_ready), 32'd0);
        src_en = 1'b0;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NS; i++) begin
            src_len[i] = 0;
            src_ptr[i] = 0;
            pend[i]    = 1'b0;
        end
    endtask

    task automatic load_frame(input int idx, input int len, input int base, input bit rnd);
        src_len[idx] = len;
        for (int k = 0; k < len; k++) begin
            src_mem[idx][k] = rnd ? 8'($urandom_range(0, 255)) : 8'(base + k);
        end
    endtask

    initial begin
        logic [NS-1:0] miss_dummy;
        int d0;
        errors = 0; checks = 0; tick_no = 0; done_seen = 0; done_tick = 0; last_tick = 0;
        exp_count = '0; prev_stall = 1'b0; prev_beat = '0; bad_ready = 1'b0; cur_mask = '0;
        src_en = 1'b0; gap_en = 1'b0; rand_rdy = 1'b0; fg_idx = -1; fg_at = 0; fg_left = 0;
        cap_missing = '0;
        clear_sources();
        aresetn_i   = 1'b0;
        surf_mask_i = '0;
        s_tdata     = '0;
        s_tvalid    = '0;
        s_tlast     = '0;
        m_tready    = 1'b1;

        // Reset state
        repeat (3) @(posedge sysclk_i);
        #2;
        check("rst_m_tdata", 32'(m_tdata), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tlast", 32'(m_tlast), 32'd0);
        check("rst_m_tuser", 32'(m_tuser), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_done", 32'(event_done_o), 32'd0);
        check("rst_missing", 32'(missing_o), 32'd0);
        check("rst_count", 32'(event_count_o), 32'd0);
        aresetn_i = 1'b1;

        // 1: all SURFs, 4-byte frames {i..i+3}
        clear_sources();
        for (int i = 0; i < NS; i++) load_frame(i, 4, i, 1'b0);
        run_event(7'h7F, 300, "t1_all");

        // 2: SURF2 silent -> skipped after exactly TO cycles; SURF1 disabled but presenting data
        clear_sources();
        load_frame(0, 3, 8'h10, 1'b0);
        load_frame(1, 3, 8'h20, 1'b0);
        run_event(7'h05, 300, "t2_timeout");
        check("t2_done_latency", 32'(done_tick - last_tick), 32'(TO + 2));
        check("t2_surf1_untouched", 32'(src_ptr[1]), 32'd0);

        // 3: 1000-byte frame, random backpressure and gaps, one gap far longer than the timeout
        clear_sources();
        load_frame(1, 1000, 0, 1'b1);
        load_frame(4, 5, 0, 1'b1);
        gap_en = 1'b1; rand_rdy = 1'b1; fg_idx = 1; fg_at = 500; fg_left = 40;
        run_event(7'h12, 20000, "t3_stress");
        gap_en = 1'b0; rand_rdy = 1'b0; fg_idx = -1;

        // 4: first and last SURF only
        clear_sources();
        load_frame(0, 3, 8'h30, 1'b0);
        load_frame(6, 2, 8'h60, 1'b0);
        run_event(7'h41, 300, "t4_ends");

        // 5: reset in the middle of SURF3's frame
        clear_sources();
        load_frame(3, 6, 8'h70, 1'b0);
        load_frame(5, 3, 8'h80, 1'b0);
        prepare(7'h28, miss_dummy);
        repeat (6) tick();
        check("t5_midframe_valid", 32'(m_tvalid), 32'd1);
        check("t5_midframe_user", 32'(m_tuser), 32'd3);
        aresetn_i = 1'b0;
        #1;
        check("t5_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("t5_rst_m_tdata", 32'(m_tdata), 32'd0);
        check("t5_rst_m_tlast", 32'(m_tlast), 32'd0);
        check("t5_rst_m_tuser", 32'(m_tuser), 32'd0);
        check("t5_rst_s_tready", 32'(s_tready), 32'd0);
        check("t5_rst_done", 32'(event_done_o), 32'd0);
        check("t5_rst_missing", 32'(missing_o), 32'd0);
        check("t5_rst_count", 32'(event_count_o), 32'd0);
        @(posedge sysclk_i);
        #2;
        src_en = 1'b0;
        for (int i = 0; i < NS; i++) begin
            src_ptr[i] = 0;
            pend[i]    = 1'b0;
        end
        exp_q.delete();
        prev_stall = 1'b0;
        exp_count  = '0;
        aresetn_i  = 1'b1;
        run_event(7'h28, 300, "t5_after_reset");

        // 6: single-SURF events through the 4-bit counter wrap, then an all-disabled mask
        clear_sources();
        load_frame(0, 2, 8'h90, 1'b0);
        for (int e = 0; e < 16; e++) run_event(7'h01, 60, "t6_wrap");
        check("t6_single_latency", 32'(done_tick - last_tick), 32'd1);
        prepare(7'h00, miss_dummy);
        d0 = done_seen;
        repeat (30) tick();
        check("t6_mask0_no_done", 32'(done_seen - d0), 32'd0);
        check("t6_mask0_no_accept", 32'(src_ptr[0]), 32'd0);
        check("t6_mask0_ready", 32'(bad_ready), 32'd0);
        check("t6_mask0_count", 32'(event_count_o), 32'(exp_count));
        src_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
